// File: rtl/alu_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter_pkg
//   Shared definitions for the ALU request arbiter:
//     - arb_state_t     : FSM state encoding (IDLE -> EXEC -> RESP)
//     - MUL_CMD_*       : commands that take the multiply latency when the
//                         request is in arithmetic mode (CMD 9 and CMD 10)
//     - FLAG_*          : bit positions inside RSP_FLAGS
//                         {COUT,OFLOW,G,E,L,ERR} = bits {5,4,3,2,1,0}
//     - is_mul_cmd()    : helper that classifies a command/mode pair
// ---------------------------------------------------------------------------
package alu_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam int MUL_CMD_A = 9;
  localparam int MUL_CMD_B = 10;

  localparam int FLAG_ERR   = 0;
  localparam int FLAG_L     = 1;
  localparam int FLAG_E     = 2;
  localparam int FLAG_G     = 3;
  localparam int FLAG_OFLOW = 4;
  localparam int FLAG_COUT  = 5;
  localparam int NFLAGS     = 6;

  // Multiply commands are only meaningful in arithmetic mode; in logical
  // mode the same encodings are ordinary single-latency operations.
  function automatic logic is_mul_cmd(input logic mode, input logic [31:0] cmd);
    return mode && ((cmd == 32'(MUL_CMD_A)) || (cmd == 32'(MUL_CMD_B)));
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter_rr_pick
//   Combinational rotate-priority picker. Searches req starting at ptr+1
//   (wrapping modulo NREQ) and returns the first set bit.
// Ports
//   req        in   NREQ   request vector
//   ptr        in   IDW    index of the most recent winner
//   gnt_onehot out  NREQ   one-hot winner (all zero when req == 0)
//   gnt_idx    out  IDW    binary index of the winner (0 when none)
//   gnt_any    out  1      at least one request present
// ---------------------------------------------------------------------------
module alu_req_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    cand       = '0;
    // Offset NREQ wraps back to ptr itself, so the previous winner is
    // considered last and only wins when it is the sole requester.
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDW'((int'(ptr) + off) % NREQ);
      if (!gnt_any && req[cand]) begin
        gnt_any          = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
//   Shares one ALU between NREQ requesters. A round-robin pick latches the
//   winner's operands, drives the ALU with ALU_CE high for LAT cycles
//   (MUL_LAT for arithmetic-mode multiply commands), then captures the ALU
//   outputs into a tagged one-cycle response. All outputs are registered.
//
// Optional feature (compile-time macro ALU_ARB_PRIO0_EN):
//   defined     : requester 0 has strict priority; round-robin among
//                 1..NREQ-1 only when REQ[0]=0; requester-0 grants leave the
//                 round-robin pointer untouched.
//   not defined : pure round-robin across all requesters.
//
// Ports
//   CLK            in   1               clock, rising edge
//   RST            in   1               asynchronous reset, active high
//   REQ            in   NREQ            per-requester request level
//   REQ_OPA/OPB    in   NREQ*WIDTH_OP   packed operands, slice i = requester i
//   REQ_CMD        in   NREQ*WIDTH_CMD  packed commands
//   REQ_MODE       in   NREQ            1 = arithmetic, 0 = logical
//   REQ_CIN        in   NREQ            carry in
//   REQ_INP_VALID  in   NREQ*2          packed operand-valid flags
//   GNT            out  NREQ            one-hot grant, 1-cycle pulse
//   ALU_*          out                  operands/controls to the ALU
//   ALU_RES/flags  in                   results from the ALU
//   RSP_VALID      out  1               response pulse
//   RSP_ID         out  $clog2(NREQ)    owner of the response
//   RSP_RES        out  WIDTH_RES       captured result
//   RSP_FLAGS      out  6               {COUT,OFLOW,G,E,L,ERR}
//   BUSY           out  1               state is not IDLE
// ---------------------------------------------------------------------------
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH_OP  = 8,
  parameter int WIDTH_CMD = 4,
  parameter int WIDTH_RES = 16,
  parameter int LAT       = 2,
  parameter int MUL_LAT   = 3,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NREQ-1:0]           REQ,
  input  logic [NREQ*WIDTH_OP-1:0]  REQ_OPA,
  input  logic [NREQ*WIDTH_OP-1:0]  REQ_OPB,
  input  logic [NREQ*WIDTH_CMD-1:0] REQ_CMD,
  input  logic [NREQ-1:0]           REQ_MODE,
  input  logic [NREQ-1:0]           REQ_CIN,
  input  logic [NREQ*2-1:0]         REQ_INP_VALID,
  output logic [NREQ-1:0]           GNT,
  output logic [WIDTH_OP-1:0]       ALU_OPA,
  output logic [WIDTH_OP-1:0]       ALU_OPB,
  output logic [WIDTH_CMD-1:0]      ALU_CMD,
  output logic                      ALU_MODE,
  output logic                      ALU_CIN,
  output logic                      ALU_CE,
  output logic [1:0]                ALU_INP_VALID,
  input  logic [WIDTH_RES-1:0]      ALU_RES,
  input  logic                      ALU_COUT,
  input  logic                      ALU_OFLOW,
  input  logic                      ALU_G,
  input  logic                      ALU_E,
  input  logic                      ALU_L,
  input  logic                      ALU_ERR,
  output logic                      RSP_VALID,
  output logic [IDW-1:0]            RSP_ID,
  output logic [WIDTH_RES-1:0]      RSP_RES,
  output logic [NFLAGS-1:0]         RSP_FLAGS,
  output logic                      BUSY
);

  localparam int MAX_LAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  // -------------------------------------------------------------------------
  // Unpack the per-requester slices so the winner can be selected by index.
  // -------------------------------------------------------------------------
  logic [WIDTH_OP-1:0]  opa_arr  [NREQ];
  logic [WIDTH_OP-1:0]  opb_arr  [NREQ];
  logic [WIDTH_CMD-1:0] cmd_arr  [NREQ];
  logic [1:0]           ival_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign opa_arr[gi]  = REQ_OPA[gi*WIDTH_OP +: WIDTH_OP];
      assign opb_arr[gi]  = REQ_OPB[gi*WIDTH_OP +: WIDTH_OP];
      assign cmd_arr[gi]  = REQ_CMD[gi*WIDTH_CMD +: WIDTH_CMD];
      assign ival_arr[gi] = REQ_INP_VALID[gi*2 +: 2];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  arb_state_t           state_reg,     state_next;
  logic [IDW-1:0]       ptr_reg,       ptr_next;
  logic [IDW-1:0]       owner_reg,     owner_next;
  logic [CNT_W-1:0]     cnt_reg,       cnt_next;
  logic [NREQ-1:0]      gnt_reg,       gnt_next;
  logic [WIDTH_OP-1:0]  alu_opa_reg,   alu_opa_next;
  logic [WIDTH_OP-1:0]  alu_opb_reg,   alu_opb_next;
  logic [WIDTH_CMD-1:0] alu_cmd_reg,   alu_cmd_next;
  logic                 alu_mode_reg,  alu_mode_next;
  logic                 alu_cin_reg,   alu_cin_next;
  logic                 alu_ce_reg,    alu_ce_next;
  logic [1:0]           alu_ival_reg,  alu_ival_next;
  logic                 rsp_valid_reg, rsp_valid_next;
  logic [IDW-1:0]       rsp_id_reg,    rsp_id_next;
  logic [WIDTH_RES-1:0] rsp_res_reg,   rsp_res_next;
  logic [NFLAGS-1:0]    rsp_flags_reg, rsp_flags_next;
  logic                 busy_reg,      busy_next;

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
  logic [NREQ-1:0] rr_req;
  logic [NREQ-1:0] rr_onehot;
  logic [IDW-1:0]  rr_idx;
  logic            rr_any;

  logic [NREQ-1:0] win_onehot;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic            ptr_update;

  alu_req_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req        (rr_req),
    .ptr        (ptr_reg),
    .gnt_onehot (rr_onehot),
    .gnt_idx    (rr_idx),
    .gnt_any    (rr_any)
  );

`ifdef ALU_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation entirely and never moves the pointer,
  // so the remaining requesters keep their round-robin order across its grants.
  assign rr_req     = {REQ[NREQ-1:1], 1'b0};
  assign win_any    = REQ[0] | rr_any;
  assign win_onehot = REQ[0] ? {{(NREQ-1){1'b0}}, 1'b1} : rr_onehot;
  assign win_idx    = REQ[0] ? '0 : rr_idx;
  assign ptr_update = ~REQ[0];
`else
  assign rr_req     = REQ;
  assign win_any    = rr_any;
  assign win_onehot = rr_onehot;
  assign win_idx    = rr_idx;
  assign ptr_update = 1'b1;
`endif

  logic win_is_mul;
  assign win_is_mul = is_mul_cmd(REQ_MODE[win_idx], 32'(cmd_arr[win_idx]));

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    owner_next     = owner_reg;
    cnt_next       = cnt_reg;
    gnt_next       = '0;
    alu_opa_next   = alu_opa_reg;
    alu_opb_next   = alu_opb_reg;
    alu_cmd_next   = alu_cmd_reg;
    alu_mode_next  = alu_mode_reg;
    alu_cin_next   = alu_cin_reg;
    alu_ce_next    = alu_ce_reg;
    alu_ival_next  = alu_ival_reg;
    rsp_valid_next = 1'b0;
    rsp_id_next    = rsp_id_reg;
    rsp_res_next   = rsp_res_reg;
    rsp_flags_next = rsp_flags_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (win_any) begin
          gnt_next      = win_onehot;
          alu_opa_next  = opa_arr[win_idx];
          alu_opb_next  = opb_arr[win_idx];
          alu_cmd_next  = cmd_arr[win_idx];
          alu_mode_next = REQ_MODE[win_idx];
          alu_cin_next  = REQ_CIN[win_idx];
          alu_ival_next = ival_arr[win_idx];
          alu_ce_next   = 1'b1;
          cnt_next      = win_is_mul ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
          owner_next    = win_idx;
          if (ptr_update) begin
            ptr_next = win_idx;
          end
          state_next    = ST_EXEC;
        end
      end

      ST_EXEC: begin
        cnt_next = cnt_reg - CNT_W'(1);
        // The edge on which cnt reads 1 is the last one with ALU_CE high,
        // so the ALU outputs are sampled while they are still being driven.
        if (cnt_reg == CNT_W'(1)) begin
          rsp_res_next   = ALU_RES;
          rsp_flags_next = {ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR};
          rsp_id_next    = owner_reg;
          rsp_valid_next = 1'b1;
          alu_ce_next    = 1'b0;
          state_next     = ST_RESP;
        end
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= IDW'(NREQ - 1);
      owner_reg     <= '0;
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      alu_opa_reg   <= '0;
      alu_opb_reg   <= '0;
      alu_cmd_reg   <= '0;
      alu_mode_reg  <= 1'b0;
      alu_cin_reg   <= 1'b0;
      alu_ce_reg    <= 1'b0;
      alu_ival_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_res_reg   <= '0;
      rsp_flags_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      owner_reg     <= owner_next;
      cnt_reg       <= cnt_next;
      gnt_reg       <= gnt_next;
      alu_opa_reg   <= alu_opa_next;
      alu_opb_reg   <= alu_opb_next;
      alu_cmd_reg   <= alu_cmd_next;
      alu_mode_reg  <= alu_mode_next;
      alu_cin_reg   <= alu_cin_next;
      alu_ce_reg    <= alu_ce_next;
      alu_ival_reg  <= alu_ival_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_res_reg   <= rsp_res_next;
      rsp_flags_reg <= rsp_flags_next;
      busy_reg      <= busy_next;
    end
  end

  assign GNT           = gnt_reg;
  assign ALU_OPA       = alu_opa_reg;
  assign ALU_OPB       = alu_opb_reg;
  assign ALU_CMD       = alu_cmd_reg;
  assign ALU_MODE      = alu_mode_reg;
  assign ALU_CIN       = alu_cin_reg;
  assign ALU_CE        = alu_ce_reg;
  assign ALU_INP_VALID = alu_ival_reg;
  assign RSP_VALID     = rsp_valid_reg;
  assign RSP_ID        = rsp_id_reg;
  assign RSP_RES       = rsp_res_reg;
  assign RSP_FLAGS     = rsp_flags_reg;
  assign BUSY          = busy_reg;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_req_arbiter
//   Directed bench for alu_req_arbiter (NREQ=4, LAT=2, MUL_LAT=3) with a
//   combinational ALU stub: CMD0 = add with carry, CMD9 = multiply,
//   others = XOR; G/E/L compare the operands; ERR = (INP_VALID != 11).
//   The strict-priority scenario runs only when ALU_ARB_PRIO0_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_opa = '0;
  logic [31:0] req_opb = '0;
  logic [15:0] req_cmd = '0;
  logic [3:0]  req_mode = '0;
  logic [3:0]  req_cin = '0;
  logic [7:0]  req_iv = '0;

  logic [3:0]  gnt;
  logic [7:0]  alu_opa, alu_opb;
  logic [3:0]  alu_cmd;
  logic        alu_mode, alu_cin, alu_ce;
  logic [1:0]  alu_iv;
  logic [15:0] stub_res;
  logic        stub_cout, stub_oflow, stub_g, stub_e, stub_l, stub_err;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_res;
  logic [5:0]  rsp_flags;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(
    .NREQ(4), .WIDTH_OP(8), .WIDTH_CMD(4), .WIDTH_RES(16), .LAT(2), .MUL_LAT(3)
  ) dut (
    .CLK(clk), .RST(rst), .REQ(req),
    .REQ_OPA(req_opa), .REQ_OPB(req_opb), .REQ_CMD(req_cmd),
    .REQ_MODE(req_mode), .REQ_CIN(req_cin), .REQ_INP_VALID(req_iv),
    .GNT(gnt),
    .ALU_OPA(alu_opa), .ALU_OPB(alu_opb), .ALU_CMD(alu_cmd),
    .ALU_MODE(alu_mode), .ALU_CIN(alu_cin), .ALU_CE(alu_ce),
    .ALU_INP_VALID(alu_iv),
    .ALU_RES(stub_res), .ALU_COUT(stub_cout), .ALU_OFLOW(stub_oflow),
    .ALU_G(stub_g), .ALU_E(stub_e), .ALU_L(stub_l), .ALU_ERR(stub_err),
    .RSP_VALID(rsp_valid), .RSP_ID(rsp_id), .RSP_RES(rsp_res),
    .RSP_FLAGS(rsp_flags), .BUSY(busy)
  );

  // ALU stub
  logic [8:0] stub_sum;
  always_comb begin
    stub_sum   = {1'b0, alu_opa} + {1'b0, alu_opb} + {8'd0, alu_cin};
    stub_res   = {8'd0, alu_opa ^ alu_opb};
    stub_cout  = 1'b0;
    stub_oflow = 1'b0;
    case (alu_cmd)
      4'd0: begin stub_res = {7'd0, stub_sum}; stub_cout = stub_sum[8]; end
      4'd9: stub_res = {8'd0, alu_opa} * {8'd0, alu_opb};
      default: ;
    endcase
    stub_g   = (alu_opa > alu_opb);
    stub_e   = (alu_opa == alu_opb);
    stub_l   = (alu_opa < alu_opb);
    stub_err = (alu_iv != 2'b11);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_slice(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] c, input logic m, input logic ci,
                           input logic [1:0] iv);
    req_opa[i*8 +: 8] = a;
    req_opb[i*8 +: 8] = b;
    req_cmd[i*4 +: 4] = c;
    req_mode[i]       = m;
    req_cin[i]        = ci;
    req_iv[i*2 +: 2]  = iv;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({gnt, alu_ce, rsp_valid, busy, alu_opa, rsp_res, rsp_flags} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: gnt=%b ce=%b rv=%b busy=%b opa=%h res=%h flags=%b, required all 0",
               gnt, alu_ce, rsp_valid, busy, alu_opa, rsp_res, rsp_flags);
    end
    rst = 1'b0;
    tick();
    // request withdrawn before the sampling edge must not be granted
    set_slice(0, 8'h05, 8'h03, 4'd0, 1'b1, 1'b0, 2'b11);
    req = 4'b0001;
    #2;
    req = 4'b0000;
    tick();
    vectors++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dropped_req: gnt=%b busy=%b, required 0000/0", gnt, busy);
    end
    $display("reset: outputs checked, dropped request ignored");
  endtask

  task automatic test_single_add();
    set_slice(0, 8'h05, 8'h03, 4'd0, 1'b1, 1'b0, 2'b11);
    req = 4'b0001;
    tick();                                   // grant edge
    vectors++;
    if (gnt !== 4'b0001 || alu_ce !== 1'b1 || alu_opa !== 8'h05 || alu_opb !== 8'h03 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL add_grant: gnt=%b ce=%b opa=%h opb=%h busy=%b, required 0001/1/05/03/1",
               gnt, alu_ce, alu_opa, alu_opb, busy);
    end
    req = 4'b0000;
    tick();                                   // EXEC, cnt 2 -> 1
    vectors++;
    if (gnt !== 4'b0000 || alu_ce !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_exec: gnt=%b ce=%b rv=%b, required 0000/1/0", gnt, alu_ce, rsp_valid);
    end
    // request raised while busy: must wait until IDLE
    set_slice(3, 8'h01, 8'h01, 4'd0, 1'b1, 1'b0, 2'b11);
    req = 4'b1000;
    tick();                                   // capture edge
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_res !== 16'h0008 ||
        rsp_flags !== 6'b001000 || alu_ce !== 1'b0 || gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL add_rsp: rv=%b id=%0d res=%h flags=%b ce=%b gnt=%b, required 1/0/0008/001000/0/0000",
               rsp_valid, rsp_id, rsp_res, rsp_flags, alu_ce, gnt);
    end
    tick();                                   // RESP -> IDLE
    vectors++;
    if (rsp_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 || rsp_res !== 16'h0008) begin
      miscompares++;
      $display("FAIL add_resp_state: rv=%b gnt=%b busy=%b res=%h, required 0/0000/0/0008",
               rsp_valid, gnt, busy, rsp_res);
    end
    tick();                                   // pending request granted
    vectors++;
    if (gnt !== 4'b1000 || rsp_id !== 2'd0) begin
      miscompares++;
      $display("FAIL add_pending_grant: gnt=%b id=%0d, required 1000/0", gnt, rsp_id);
    end
    req = 4'b0000;
    $display("single_add: 5+3 -> res=%h id=%0d", rsp_res, rsp_id);
    wait_idle("add");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         exp_idx [5] = '{0, 1, 2, 3, 0};
    int         last_cyc = 0;
    for (int i = 0; i < 4; i++) set_slice(i, 8'(i + 1), 8'h10, 4'd0, 1'b1, 1'b0, 2'b11);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      tick();
      while (gnt === 4'b0000 && n < 12) begin
        if (rsp_valid === 1'b1 && k > 0) begin
          vectors++;
          if (rsp_id !== 2'(exp_idx[k-1]) || rsp_res !== 16'(17 + exp_idx[k-1])) begin
            miscompares++;
            $display("FAIL b2b_rsp%0d: id=%0d res=%h, required %0d/%h",
                     k, rsp_id, rsp_res, exp_idx[k-1], 16'(17 + exp_idx[k-1]));
          end
        end
        tick();
        n++;
      end
      vectors++;
      if (gnt !== exp_gnt[k]) begin
        miscompares++;
        $display("FAIL b2b_gnt%0d: gnt=%b, required %b", k, gnt, exp_gnt[k]);
      end
      if (k > 0) begin
        vectors++;
        if (cyc - last_cyc !== 4) begin
          miscompares++;
          $display("FAIL b2b_spacing%0d: %0d cycles, required 4", k, cyc - last_cyc);
        end
      end
      $display("back_to_back: grant %0d = %b at cycle %0d", k, gnt, cyc);
      last_cyc = cyc;
    end
    req = 4'b0000;
    wait_idle("b2b");
  endtask

  task automatic test_mul();
    int n = 0;
    int ce_cnt = 0;
    set_slice(2, 8'h03, 8'h04, 4'd9, 1'b1, 1'b0, 2'b11);
    req = 4'b0100;
    tick();
    vectors++;
    if (gnt !== 4'b0100 || alu_cmd !== 4'd9) begin
      miscompares++;
      $display("FAIL mul_grant: gnt=%b cmd=%0d, required 0100/9", gnt, alu_cmd);
    end
    req = 4'b0000;
    if (alu_ce === 1'b1) ce_cnt++;
    while (rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
      if (alu_ce === 1'b1) ce_cnt++;
    end
    vectors++;
    if (n !== 3 || ce_cnt !== 3) begin
      miscompares++;
      $display("FAIL mul_latency: rsp after %0d, ce cycles %0d, required 3/3", n, ce_cnt);
    end
    vectors++;
    if (rsp_res !== 16'h000C || rsp_id !== 2'd2) begin
      miscompares++;
      $display("FAIL mul_rsp: res=%h id=%0d, required 000c/2", rsp_res, rsp_id);
    end
    $display("mul: 3*4 -> res=%h id=%0d latency=%0d", rsp_res, rsp_id, n);
    wait_idle("mul");
  endtask

  task automatic test_reset_mid_exec();
    int seen = 0;
    set_slice(0, 8'h05, 8'h03, 4'd0, 1'b1, 1'b0, 2'b11);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();                                   // inside EXEC
    #2;
    rst = 1'b1;
    #1;                                       // before the next edge
    vectors++;
    if ({gnt, alu_ce, rsp_valid, busy, alu_opa, rsp_res, rsp_flags, rsp_id} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_clear: ce=%b rv=%b busy=%b opa=%h res=%h, required all 0",
               alu_ce, rsp_valid, busy, alu_opa, rsp_res);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL rstmid_no_rsp: %0d response pulses, required 0", seen);
    end
    req = 4'b1111;
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL rstmid_regrant: gnt=%b, required 0001", gnt);
    end
    req = 4'b0000;
    $display("reset_mid_exec: op discarded, regrant %b", gnt);
    wait_idle("rstmid");
  endtask

  task automatic test_inp_valid_err();
    int n = 0;
    set_slice(1, 8'h07, 8'h02, 4'd0, 1'b1, 1'b0, 2'b00);
    req = 4'b0010;
    tick();
    vectors++;
    if (gnt !== 4'b0010 || alu_iv !== 2'b00) begin
      miscompares++;
      $display("FAIL err_grant: gnt=%b iv=%b, required 0010/00", gnt, alu_iv);
    end
    req = 4'b0000;
    while (rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== 2 || rsp_id !== 2'd1 || rsp_flags[0] !== 1'b1 ||
        rsp_flags !== 6'b001001 || rsp_res !== 16'h0009) begin
      miscompares++;
      $display("FAIL err_rsp: lat=%0d id=%0d flags=%b res=%h, required 2/1/001001/0009",
               n, rsp_id, rsp_flags, rsp_res);
    end
    $display("inp_valid_err: flags=%b id=%0d", rsp_flags, rsp_id);
    wait_idle("err");
  endtask

`ifdef ALU_ARB_PRIO0_EN
  task automatic test_prio0();
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_slice(i, 8'(i), 8'h01, 4'd0, 1'b1, 1'b0, 2'b11);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      tick();
      while (gnt === 4'b0000 && n < 12) begin
        tick();
        n++;
      end
      vectors++;
      if (gnt !== exp_gnt[k]) begin
        miscompares++;
        $display("FAIL prio0_gnt%0d: gnt=%b, required %b", k, gnt, exp_gnt[k]);
      end
      $display("prio0: grant %0d = %b", k, gnt);
      if (k == 2) req = 4'b1110;
    end
    req = 4'b0000;
    wait_idle("prio0");
  endtask
`endif

  initial begin
    tick();
    tick();
    test_reset();
    test_single_add();
    test_back_to_back();
    test_mul();
    test_reset_mid_exec();
    test_inp_valid_err();
`ifdef ALU_ARB_PRIO0_EN
    test_prio0();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
